// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: S-box, Rcon start value, round-key count, key-expansion state encoding
package aes_pkg;

    localparam int AES_NUM_RK = 15;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } key_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: four parallel S-box lookups on a 32-bit word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand_256.sv
// rtl/aes_key_expand_256.sv - AES-256 key expansion, one 128-bit round key per cycle into a 15-entry register file
module aes_key_expand_256
    import aes_pkg::*;
#(
    parameter int NUM_RK = AES_NUM_RK
) (
    input  logic           inClk,
    input  logic           inRstN,
    input  logic           inKeyValid,
    output logic           outKeyReady,
    input  logic [255:0]   inKey,
    input  logic [3:0]     inRkIdx,
    output logic [127:0]   outRk,
    output logic           outDone
);

    key_state_e     r_state;
    key_state_e     w_state_nxt;
    logic [127:0]   r_rk [NUM_RK];
    logic [3:0]     r_grp;
    logic [7:0]     r_rcon;
    logic [127:0]   r_rk_out;
    logic           r_done;

    logic           w_accept;
    logic           w_last_grp;
    logic [3:0]     w_prev_idx;
    logic [3:0]     w_old_idx;
    logic [31:0]    w_last_word;
    logic [127:0]   w_old_rk;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_f;
    logic [31:0]    w_k0, w_k1, w_k2, w_k3;

    assign w_accept   = inKeyValid && outKeyReady;
    assign w_last_grp = (r_grp == 4'(NUM_RK - 1));

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (inKeyValid) w_state_nxt = ST_GEN;
            ST_GEN:           if (w_last_grp) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        outKeyReady = (r_state == ST_IDLE) || (r_state == ST_DONE);
    end

    // Group g needs rk[g-2] whole and the last word of rk[g-1]
    assign w_prev_idx  = r_grp - 4'd1;
    assign w_old_idx   = r_grp - 4'd2;
    assign w_last_word = r_rk[w_prev_idx][31:0];
    assign w_old_rk    = r_rk[w_old_idx];
    assign w_sub_in    = r_grp[0] ? w_last_word : {w_last_word[23:0], w_last_word[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    assign w_f  = r_grp[0] ? w_sub_out : (w_sub_out ^ {r_rcon, 24'h0});
    assign w_k0 = w_old_rk[127:96] ^ w_f;
    assign w_k1 = w_old_rk[95:64]  ^ w_k0;
    assign w_k2 = w_old_rk[63:32]  ^ w_k1;
    assign w_k3 = w_old_rk[31:0]   ^ w_k2;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
            r_grp  <= 4'd0;
            r_rcon <= RCON_INIT;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_rk[0] <= inKey[255:128];
            r_rk[1] <= inKey[127:0];
            r_grp   <= 4'd2;
            r_rcon  <= RCON_INIT;
            r_done  <= 1'b0;
        end else if (r_state == ST_GEN) begin
            r_rk[r_grp] <= {w_k0, w_k1, w_k2, w_k3};
            r_grp       <= r_grp + 4'd1;
            if (!r_grp[0]) r_rcon <= {r_rcon[6:0], 1'b0};
            if (w_last_grp) r_done <= 1'b1;
        end
    end

    // Indices at or beyond NUM_RK read back as zero
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN)                          r_rk_out <= '0;
        else if ({1'b0, inRkIdx} < 5'(NUM_RK)) r_rk_out <= r_rk[inRkIdx];
        else                                  r_rk_out <= '0;
    end

    assign outRk   = r_rk_out;
    assign outDone = r_done;

endmodule

// File: tb/tb_aes_key_expand_256.sv
// tb/tb_aes_key_expand_256.sv - self-checking bench for aes_key_expand_256
module tb_aes_key_expand_256;

    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ZERO = 256'h0;
    localparam logic [127:0] A3_RK0   = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] A3_RK1   = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK14  = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_RK2    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK3    = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    logic           inClk;
    logic           inRstN;
    logic           inKeyValid;
    logic           outKeyReady;
    logic [255:0]   inKey;
    logic [3:0]     inRkIdx;
    logic [127:0]   outRk;
    logic           outDone;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } sb_t;

    vec_t vecs [10];
    sb_t  sb_q [$];

    aes_key_expand_256 dut (
        .inClk       (inClk),
        .inRstN      (inRstN),
        .inKeyValid  (inKeyValid),
        .outKeyReady (outKeyReady),
        .inKey       (inKey),
        .inRkIdx     (inRkIdx),
        .outRk       (outRk),
        .outDone     (outDone)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_check(input logic [3:0] idx, input logic [127:0] exp, input string name);
        sb_t s;
        @(negedge inClk);
        inRkIdx = idx;
        sb_q.push_back('{exp: exp, name: name});
        @(posedge inClk);
        #1;
        s = sb_q.pop_front();
        check(s.name, outRk, s.exp);
    endtask

    // Presents key on the next edge; optionally keeps valid high with other_key afterwards
    task automatic accept_key(input logic [255:0] key, input bit hold, input logic [255:0] other_key);
        @(negedge inClk);
        inKey      = key;
        inKeyValid = 1'b1;
        check("ready_before_accept", 128'(outKeyReady), 128'(1'b1));
        @(posedge inClk);
        #1;
        check("done_cleared_on_accept", 128'(outDone), 128'(1'b0));
        if (hold) inKey = other_key;
        else      inKeyValid = 1'b0;
    endtask

    task automatic wait_done(input bit check_busy);
        int  n;
        bit  busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!outDone && n < 20) begin
            if (check_busy && outKeyReady) busy_ok = 1'b0;
            @(posedge inClk);
            #1;
            n++;
        end
        inKeyValid = 1'b0;
        check("done_latency", 128'(n), 128'(13));
        if (check_busy) check("ready_low_in_gen", 128'(busy_ok), 128'(1'b1));
    endtask

    initial begin
        vecs[0] = '{KEY_A3,   4'd0,  A3_RK0,  "a3_rk0"};
        vecs[1] = '{KEY_A3,   4'd1,  A3_RK1,  "a3_rk1"};
        vecs[2] = '{KEY_A3,   4'd2,  A3_RK2,  "a3_rk2"};
        vecs[3] = '{KEY_A3,   4'd14, A3_RK14, "a3_rk14"};
        vecs[4] = '{KEY_A3,   4'd15, 128'h0,  "a3_idx15"};
        vecs[5] = '{KEY_ZERO, 4'd0,  128'h0,  "zero_rk0"};
        vecs[6] = '{KEY_ZERO, 4'd2,  Z_RK2,   "zero_rk2"};
        vecs[7] = '{KEY_ZERO, 4'd3,  Z_RK3,   "zero_rk3"};
        vecs[8] = '{KEY_ZERO, 4'd15, 128'h0,  "zero_idx15"};
        vecs[9] = '{KEY_A3,   4'd14, A3_RK14, "a3_rk14_reload"};

        inRstN     = 1'b0;
        inKeyValid = 1'b0;
        inKey      = '0;
        inRkIdx    = 4'd0;
        #22;
        check("reset_outrk",   outRk,           128'h0);
        check("reset_done",    128'(outDone),   128'(1'b0));
        @(negedge inClk);
        inRstN = 1'b1;
        @(posedge inClk);
        #1;
        check("ready_after_reset", 128'(outKeyReady), 128'(1'b1));

        for (int i = 0; i < 10; i++) begin
            accept_key(vecs[i].key, 1'b0, '0);
            wait_done(1'b0);
            read_check(vecs[i].idx, vecs[i].exp, vecs[i].name);
        end

        // Back-to-back reads, each visible one cycle after its index
        accept_key(KEY_A3, 1'b0, '0);
        wait_done(1'b0);
        read_check(4'd0,  A3_RK0,  "seq_idx0");
        read_check(4'd1,  A3_RK1,  "seq_idx1");
        read_check(4'd14, A3_RK14, "seq_idx14");
        read_check(4'd15, 128'h0,  "seq_idx15");

        // Valid held high with another key during expansion
        accept_key(KEY_A3, 1'b1, KEY_ZERO);
        wait_done(1'b1);
        read_check(4'd2,  A3_RK2,  "hold_rk2");
        read_check(4'd14, A3_RK14, "hold_rk14");
        accept_key(KEY_ZERO, 1'b0, '0);
        wait_done(1'b0);
        read_check(4'd2,  Z_RK2,   "hold_second_rk2");

        // Reset in the middle of expansion
        accept_key(KEY_A3, 1'b0, '0);
        repeat (6) @(posedge inClk);
        #2;
        inRstN = 1'b0;
        #1;
        check("midgen_rst_outrk", outRk,           128'h0);
        check("midgen_rst_done",  128'(outDone),   128'(1'b0));
        check("midgen_rst_ready", 128'(outKeyReady), 128'(1'b1));
        @(negedge inClk);
        inRstN = 1'b1;
        read_check(4'd0, 128'h0, "midgen_rk0_zero");
        read_check(4'd2, 128'h0, "midgen_rk2_zero");
        read_check(4'd7, 128'h0, "midgen_rk7_zero");
        repeat (16) @(posedge inClk);
        #1;
        check("midgen_no_resume", 128'(outDone), 128'(1'b0));
        accept_key(KEY_ZERO, 1'b0, '0);
        wait_done(1'b0);
        read_check(4'd2, Z_RK2, "post_rst_rk2");
        read_check(4'd3, Z_RK3, "post_rst_rk3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
